// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state, op encoding and sizing constants for the core memory arbiter
package mem_arb_pkg;
  localparam int LAT_W = 4;
  localparam int MAX_CORES = 8;
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
  typedef enum logic [1:0] {OP_NONE, OP_RD, OP_WR} op_t;
  function automatic op_t decode_op(input logic rden, input logic wren);
    return wren ? OP_WR : (rden ? OP_RD : OP_NONE);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester after ptr
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_CORES = 4,
  localparam int IDX_W = $clog2(NUM_CORES)
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic                 grant_valid,
  output logic [IDX_W-1:0]     grant
);
  logic [IDX_W-1:0] idx;
  // Scan from farthest to nearest after ptr; the nearest requester overwrites and wins
  always_comb begin
    grant_valid = 1'b0;
    grant = '0;
    idx = '0;
    for (int k = NUM_CORES; k >= 1; k--) begin
      idx = IDX_W'((int'(ptr) + k) % NUM_CORES);
      if (req[idx]) begin
        grant_valid = 1'b1;
        grant = idx;
      end
    end
  end
endmodule

// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter: round-robin arbiter serving NUM_CORES cores from one fixed-latency memory
module core_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CORES-1:0]        core_request,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  input  logic [NUM_CORES-1:0]        core_rden,
  input  logic [NUM_CORES-1:0]        core_wren,
  input  logic [NUM_CORES*DATA_W-1:0] core_write_val,
  output logic [NUM_CORES-1:0]        core_enable,
  output logic [DATA_W-1:0]           core_read_val,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic                        mem_rden,
  output logic                        mem_wren,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic                        arb_busy
);
  localparam int IDX_W = $clog2(NUM_CORES);
  state_t state, state_n;
  op_t op, op_n;
  logic [IDX_W-1:0] cur, cur_n, ptr, ptr_n, grant;
  logic [LAT_W-1:0] cnt, cnt_n;
  logic grant_valid;
  logic [NUM_CORES-1:0] en_n;
  logic [DATA_W-1:0] rv_n, wdata_n;
  logic [ADDR_W-1:0] addr_n;
  logic rden_n, wren_n;

  rr_arbiter #(.NUM_CORES(NUM_CORES)) u_rr (
    .req(core_request),
    .ptr(ptr),
    .grant_valid(grant_valid),
    .grant(grant)
  );

  // Next-state and next-output logic; memory strobes are prepared on the way into ACCESS
  always_comb begin
    state_n = state;
    op_n = op;
    cur_n = cur;
    ptr_n = ptr;
    cnt_n = cnt;
    en_n = '0;
    rv_n = core_read_val;
    addr_n = '0;
    wdata_n = '0;
    rden_n = 1'b0;
    wren_n = 1'b0;
    case (state)
      IDLE: if (grant_valid) begin
        state_n = ACCESS;
        cur_n = grant;
        op_n = decode_op(core_rden[grant], core_wren[grant]);
        addr_n = core_addr[grant*ADDR_W +: ADDR_W];
        wdata_n = core_write_val[grant*DATA_W +: DATA_W];
        rden_n = op_n == OP_RD;
        wren_n = op_n == OP_WR;
      end
      ACCESS: begin
        state_n = WAIT;
        cnt_n = LAT_W'(MEM_LATENCY);
      end
      WAIT: if (cnt == LAT_W'(1)) begin
        state_n = RESP;
        en_n = NUM_CORES'(1) << cur;
        rv_n = op == OP_RD ? mem_rdata : core_read_val;
        ptr_n = cur;
      end else begin
        cnt_n = cnt - LAT_W'(1);
      end
      default: state_n = IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any transaction in flight
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      op <= OP_NONE;
      cur <= '0;
      ptr <= IDX_W'(NUM_CORES - 1);
      cnt <= '0;
      core_enable <= '0;
      core_read_val <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_rden <= 1'b0;
      mem_wren <= 1'b0;
      arb_busy <= 1'b0;
    end else begin
      state <= state_n;
      op <= op_n;
      cur <= cur_n;
      ptr <= ptr_n;
      cnt <= cnt_n;
      core_enable <= en_n;
      core_read_val <= rv_n;
      mem_addr <= addr_n;
      mem_wdata <= wdata_n;
      mem_rden <= rden_n;
      mem_wren <= wren_n;
      arb_busy <= state_n != IDLE;
    end
  end
endmodule

// File: tb/tb_core_mem_arbiter.sv
// tb_core_mem_arbiter: directed checks of arbitration, latency, op decode and reset abort
module tb_core_mem_arbiter;
  logic clk, reset;
  logic [3:0] core_request, core_rden, core_wren;
  logic [127:0] core_addr, core_write_val;
  logic [3:0] core_enable, core_enable_4;
  logic [31:0] core_read_val, core_read_val_4, mem_addr, mem_addr_4, mem_wdata, mem_wdata_4;
  logic [31:0] mem_rdata, mem_rdata_4;
  logic mem_rden, mem_wren, arb_busy, mem_rden_4, mem_wren_4, arb_busy_4;
  logic [31:0] mem [0:255];
  int tests = 0;
  int fails = 0;

  core_mem_arbiter #(.NUM_CORES(4), .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .core_request(core_request), .core_addr(core_addr),
    .core_rden(core_rden), .core_wren(core_wren), .core_write_val(core_write_val),
    .core_enable(core_enable), .core_read_val(core_read_val), .mem_addr(mem_addr),
    .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .arb_busy(arb_busy)
  );

  core_mem_arbiter #(.NUM_CORES(4), .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(4)) dut4 (
    .clk(clk), .reset(reset), .core_request(core_request), .core_addr(core_addr),
    .core_rden(core_rden), .core_wren(core_wren), .core_write_val(core_write_val),
    .core_enable(core_enable_4), .core_read_val(core_read_val_4), .mem_addr(mem_addr_4),
    .mem_rden(mem_rden_4), .mem_wren(mem_wren_4), .mem_wdata(mem_wdata_4),
    .mem_rdata(mem_rdata_4), .arb_busy(arb_busy_4)
  );

  assign mem_rdata_4 = 32'hA5A5_A5A5;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle-latency memory model; preloaded while reset is held
  always @(posedge clk) begin
    if (!reset) begin
      mem[8'h00] <= 32'h0BAD_F00D;
      mem[8'h10] <= 32'hDEAD_BEEF;
    end
    if (mem_wren) mem[mem_addr[7:0]] <= mem_wdata;
    if (mem_rden) mem_rdata <= mem[mem_addr[7:0]];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs;
    core_request = '0;
    core_rden = '0;
    core_wren = '0;
    core_addr = '0;
    core_write_val = '0;
  endtask

  task automatic wait_ack(output int cyc, output logic [3:0] en);
    cyc = 0;
    en = '0;
    while (en == 4'b0 && cyc < 20) begin
      tick();
      cyc++;
      en = core_enable;
    end
  endtask

  task automatic test_reset;
    int cyc;
    logic [3:0] en;
    reset = 1'b0;
    core_request = 4'hF;
    core_rden = 4'hF;
    repeat (3) tick();
    tests++; if (core_enable !== 4'b0) begin fails++; $display("FAIL reset_enable: got %b, want 0000", core_enable); end
    tests++; if (core_read_val !== 32'h0) begin fails++; $display("FAIL reset_read_val: got %h, want 0", core_read_val); end
    tests++; if ({mem_rden, mem_wren, arb_busy} !== 3'b000) begin fails++; $display("FAIL reset_strobes: got %b, want 000", {mem_rden, mem_wren, arb_busy}); end
    tests++; if ({mem_addr, mem_wdata} !== 64'h0) begin fails++; $display("FAIL reset_mem_bus: got %h, want 0", {mem_addr, mem_wdata}); end
    tests++; if ({core_enable_4, arb_busy_4} !== 5'b0) begin fails++; $display("FAIL reset_lat4: got %b, want 00000", {core_enable_4, arb_busy_4}); end
    reset = 1'b1;
    wait_ack(cyc, en);
    tests++; if (en !== 4'b0001) begin fails++; $display("FAIL reset_first_grant: got %b, want 0001", en); end
    tests++; if (cyc !== 3) begin fails++; $display("FAIL reset_first_latency: got %0d, want 3", cyc); end
    clear_inputs();
    tick();
  endtask

  task automatic test_single_read;
    core_request[2] = 1'b1;
    core_rden[2] = 1'b1;
    core_addr[2*32 +: 32] = 32'h10;
    tick();
    tests++; if ({mem_rden, mem_wren, arb_busy} !== 3'b101) begin fails++; $display("FAIL read_strobe: got %b, want 101", {mem_rden, mem_wren, arb_busy}); end
    tests++; if (mem_addr !== 32'h10) begin fails++; $display("FAIL read_addr: got %h, want 10", mem_addr); end
    tests++; if (core_enable !== 4'b0) begin fails++; $display("FAIL read_early_ack_c1: got %b, want 0000", core_enable); end
    tick();
    tests++; if ({core_enable, mem_rden} !== 5'b0) begin fails++; $display("FAIL read_wait_c2: got %b, want 00000", {core_enable, mem_rden}); end
    tick();
    tests++; if (core_enable !== 4'b0100) begin fails++; $display("FAIL read_ack: got %b, want 0100", core_enable); end
    tests++; if (core_read_val !== 32'hDEAD_BEEF) begin fails++; $display("FAIL read_data: got %h, want deadbeef", core_read_val); end
    clear_inputs();
    tick();
    tests++; if ({core_enable, arb_busy} !== 5'b0) begin fails++; $display("FAIL read_after: got %b, want 00000", {core_enable, arb_busy}); end
  endtask

  task automatic test_round_robin;
    int cyc;
    logic [3:0] en;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    core_request = 4'hF;
    core_rden = 4'hF;
    for (int k = 0; k < 5; k++) begin
      wait_ack(cyc, en);
      tests++; if (en !== 4'(1 << (k % 4))) begin fails++; $display("FAIL rr_order_%0d: got %b, want %b", k, en, 4'(1 << (k % 4))); end
      tests++; if (cyc !== (k == 0 ? 3 : 4)) begin fails++; $display("FAIL rr_spacing_%0d: got %0d, want %0d", k, cyc, k == 0 ? 3 : 4); end
    end
    tests++; if (core_read_val !== 32'h0BAD_F00D) begin fails++; $display("FAIL rr_last_data: got %h, want 0badf00d", core_read_val); end
    clear_inputs();
    tick();
  endtask

  task automatic test_write_conflict;
    int cyc;
    logic [3:0] en;
    core_request[1] = 1'b1;
    core_rden[1] = 1'b1;
    core_wren[1] = 1'b1;
    core_addr[1*32 +: 32] = 32'h20;
    core_write_val[1*32 +: 32] = 32'h1234_5678;
    tick();
    tests++; if ({mem_wren, mem_rden} !== 2'b10) begin fails++; $display("FAIL wr_strobes: got %b, want 10", {mem_wren, mem_rden}); end
    tests++; if ({mem_addr, mem_wdata} !== {32'h20, 32'h1234_5678}) begin fails++; $display("FAIL wr_bus: got %h, want 0000002012345678", {mem_addr, mem_wdata}); end
    wait_ack(cyc, en);
    tests++; if (en !== 4'b0010 || cyc !== 2) begin fails++; $display("FAIL wr_ack: got %b after %0d, want 0010 after 2", en, cyc); end
    tests++; if (core_read_val !== 32'h0BAD_F00D) begin fails++; $display("FAIL wr_read_val_kept: got %h, want 0badf00d", core_read_val); end
    clear_inputs();
    tick();
    tests++; if (mem[8'h20] !== 32'h1234_5678) begin fails++; $display("FAIL wr_mem: got %h, want 12345678", mem[8'h20]); end
  endtask

  task automatic test_reset_mid;
    int cyc;
    logic [3:0] en;
    core_request[2] = 1'b1;
    core_rden[2] = 1'b1;
    core_addr[2*32 +: 32] = 32'h10;
    tick();
    tests++; if (mem_rden !== 1'b1) begin fails++; $display("FAIL rst_mid_access: got %b, want 1", mem_rden); end
    tick();
    reset = 1'b0;
    tick();
    tests++; if ({core_enable, arb_busy, mem_rden, mem_wren} !== 7'b0) begin fails++; $display("FAIL rst_mid_abort: got %b, want 0000000", {core_enable, arb_busy, mem_rden, mem_wren}); end
    reset = 1'b1;
    core_request = 4'hF;
    core_rden = 4'hF;
    wait_ack(cyc, en);
    tests++; if (en !== 4'b0001 || cyc !== 3) begin fails++; $display("FAIL rst_mid_ptr: got %b after %0d, want 0001 after 3", en, cyc); end
    clear_inputs();
    tick();
  endtask

  task automatic test_drop_mid;
    core_request[3] = 1'b1;
    core_rden[3] = 1'b1;
    core_addr[3*32 +: 32] = 32'h10;
    tick();
    tests++; if (mem_addr !== 32'h10 || mem_rden !== 1'b1) begin fails++; $display("FAIL drop_access: got %h/%b, want 10/1", mem_addr, mem_rden); end
    tick();
    core_request[3] = 1'b0;
    core_addr[3*32 +: 32] = 32'h20;
    tick();
    tests++; if (core_enable !== 4'b1000) begin fails++; $display("FAIL drop_ack: got %b, want 1000", core_enable); end
    tests++; if (core_read_val !== 32'hDEAD_BEEF) begin fails++; $display("FAIL drop_data: got %h, want deadbeef", core_read_val); end
    tick();
    tests++; if ({core_enable, arb_busy} !== 5'b0) begin fails++; $display("FAIL drop_no_regrant: got %b, want 00000", {core_enable, arb_busy}); end
    clear_inputs();
  endtask

  task automatic test_latency4;
    int cyc;
    logic strobe;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    core_request[1] = 1'b1;
    cyc = 0;
    strobe = 1'b0;
    while (core_enable_4 == 4'b0 && cyc < 20) begin
      tick();
      cyc++;
      strobe = strobe | mem_rden_4 | mem_wren_4 | mem_rden | mem_wren;
      if (cyc == 3) begin
        tests++; if (core_enable !== 4'b0010) begin fails++; $display("FAIL nop_lat1_ack: got %b, want 0010", core_enable); end
      end
    end
    tests++; if (cyc !== 6) begin fails++; $display("FAIL nop_lat4_cycles: got %0d, want 6", cyc); end
    tests++; if (core_enable_4 !== 4'b0010) begin fails++; $display("FAIL nop_lat4_ack: got %b, want 0010", core_enable_4); end
    tests++; if (strobe !== 1'b0) begin fails++; $display("FAIL nop_strobe: got %b, want 0", strobe); end
    tests++; if (core_read_val_4 !== 32'h0 || core_read_val !== 32'h0) begin fails++; $display("FAIL nop_read_val: got %h/%h, want 0/0", core_read_val_4, core_read_val); end
    clear_inputs();
    tick();
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_read();
    test_round_robin();
    test_write_conflict();
    test_reset_mid();
    test_drop_mid();
    test_latency4();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
